// File: rtl/seg7_scan_reader_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan reader.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0011000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam bcd_t BCD_BLANK   = 4'hF;
  localparam bcd_t BCD_INVALID = 4'hE;

  function automatic logic is_digit(bcd_t code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: frame handshake between the scan reader and its consumer.
//   bcd_out     : frame, digit i at [4i+3:4i]
//   digit_valid : bit i set when digit i decoded to 0-9
//   frame_valid : frame available (master drives)
//   frame_ready : consumer accepts the frame (slave drives)
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (output bcd_out, output digit_valid, output frame_valid, input frame_ready);
  modport slave  (input bcd_out, input digit_valid, input frame_valid, output frame_ready);
endinterface

// File: rtl/seg7_scan_reader_seg7_to_bcd.sv
// seg7_to_bcd: combinational active-low 7-segment pattern to BCD lookup.
//   seg : segment pattern {g,f,e,d,c,b,a}, 0 = lit
//   bcd : 0-9, BCD_BLANK for an unlit digit, BCD_INVALID otherwise
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  seg7_t seg,
  output bcd_t  bcd
);

  always_comb begin
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   bcd = BCD_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: watches a multiplexed common-anode 7-segment bus, decodes
// each strobed digit, filters it for stability and hands complete frames to a
// consumer over a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : segment lines {g,f,e,d,c,b,a}, active-low
//   an_in       : anode strobes, active-low, bit i = digit i
//   frame       : master side of seg7_scan_reader_if (bcd_out, digit_valid,
//                 frame_valid out; frame_ready in)
//   overlap_err : one-cycle pulse when more than one anode goes active
//   code_err    : one-cycle pulse when an unrecognised pattern commits
//   stale       : no sample within TIMEOUT cycles
// Optional feature: define SEG7_SCAN_TIMEOUT_EN to build the idle counter that
// drives stale; otherwise stale is constant 0 and TIMEOUT has no effect.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SETTLE     = 2,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  seg7_t                  seg_in,
  input  logic [NUM_DIGITS-1:0]  an_in,
  seg7_scan_reader_if.master     frame,
  output logic                   overlap_err,
  output logic                   code_err,
  output logic                   stale
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CNT);

  seg7_t                 seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [SW-1:0]         settle_cnt;
  logic                  multi_q;
  logic                  one_low, multi_low, sample;
  logic [IW-1:0]         dig_idx;
  bcd_t                  sample_code;

  bcd_t                  cand      [NUM_DIGITS];
  logic [CW-1:0]         scnt      [NUM_DIGITS];
  bcd_t                  committed [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] cflag;
  logic [CW-1:0]         next_cnt;
  logic                  commit;
  logic                  idle_hit;

  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   dv_q;
  logic                    fv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1  <= '1;
      seg_s2  <= '1;
      an_s1   <= '1;
      an_s2   <= '1;
      an_prev <= '1;
    end else begin
      seg_s1  <= seg_in;
      seg_s2  <= seg_s1;
      an_s1   <= an_in;
      an_s2   <= an_s1;
      an_prev <= an_s2;
    end
  end

  always_comb begin
    one_low   = ($countones(~an_s2) == 1);
    multi_low = ($countones(~an_s2) > 1);
    dig_idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2[i]) dig_idx = IW'(i);
    end
  end

  // The counter parks at SETTLE after the sample, so each strobe samples once.
  assign sample = one_low && (an_s2 == an_prev) && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt  <= '0;
      multi_q     <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      multi_q     <= multi_low;
      overlap_err <= multi_low && !multi_q;
      if (one_low && (an_s2 == an_prev)) begin
        if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  seg7_to_bcd u_dec (
    .seg (seg_s2),
    .bcd (sample_code)
  );

  always_comb begin
    if (sample_code == cand[dig_idx]) begin
      next_cnt = (scnt[dig_idx] == STABLE_MAX) ? STABLE_MAX : scnt[dig_idx] + 1'b1;
    end else begin
      next_cnt = CW'(1);
    end
    commit = sample && (next_cnt >= STABLE_MAX);
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] idle_cnt;
  logic        stale_q;

  assign idle_hit = !sample && (idle_cnt == TIMEOUT_LAST);
  assign stale    = stale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      stale_q  <= 1'b0;
    end else if (sample) begin
      idle_cnt <= '0;
      stale_q  <= 1'b0;
    end else begin
      if (idle_cnt != TIMEOUT_MAX) idle_cnt <= idle_cnt + 1'b1;
      if (idle_hit) stale_q <= 1'b1;
    end
  end
`else
  assign idle_hit = 1'b0;
  // Constant 0: TIMEOUT only matters when the idle counter is built.
  assign stale    = (TIMEOUT < 0);
`endif

  // Frame clear is written before the per-digit commit so that a commit on the
  // latch cycle survives and counts toward the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '{default: '0};
      scnt      <= '{default: '0};
      committed <= '{default: BCD_BLANK};
      cflag     <= '0;
      bcd_q     <= '1;
      dv_q      <= '0;
      fv_q      <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      code_err <= commit && (sample_code == BCD_INVALID);
      if (idle_hit) scnt <= '{default: '0};
      if (!fv_q && (&cflag) && !stale) begin
        fv_q  <= 1'b1;
        cflag <= '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          bcd_q[4*i +: 4] <= committed[i];
          dv_q[i]         <= is_digit(committed[i]);
        end
      end else if (fv_q && frame.frame_ready) begin
        fv_q <= 1'b0;
      end
      if (sample) begin
        cand[dig_idx] <= sample_code;
        scnt[dig_idx] <= next_cnt;
        if (commit) begin
          committed[dig_idx] <= sample_code;
          cflag[dig_idx]     <= 1'b1;
        end
      end
    end
  end

  assign frame.bcd_out     = bcd_q;
  assign frame.digit_valid = dv_q;
  assign frame.frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed bench for seg7_scan_reader. Stimulus queues the
// expected frame; a negedge monitor pops and compares on each handshake.
module tb_seg7_scan_reader;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam seg7_t SEG_BAD = 7'b0110110;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  seg7_t         seg_in;
  logic [ND-1:0] an_in;
  logic          overlap_err, code_err, stale;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   code_err_cnt = 0;
  int   overlap_cnt = 0;
  int   base;

  seg7_scan_reader_if #(.NUM_DIGITS(ND)) frame_if ();

  seg7_scan_reader #(
    .NUM_DIGITS (ND),
    .SETTLE     (2),
    .STABLE_CNT (3),
    .TIMEOUT    (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame       (frame_if),
    .overlap_err (overlap_err),
    .code_err    (code_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got no finish required finish");
    $fatal(1);
  end

  // Monitor: counts error pulses and checks every accepted frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (code_err) code_err_cnt++;
      if (overlap_err) overlap_cnt++;
      if (frame_if.frame_valid && frame_if.frame_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got bcd=%h dv=%b required no frame",
                   frame_if.bcd_out, frame_if.digit_valid);
        end else begin
          e = exp_q.pop_front();
          if (frame_if.bcd_out !== e.bcd || frame_if.digit_valid !== e.dv) begin
            errors++;
            $display("FAIL frame got bcd=%h dv=%b required bcd=%h dv=%b",
                     frame_if.bcd_out, frame_if.digit_valid, e.bcd, e.dv);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic strobe(input int d, input seg7_t s);
    logic [ND-1:0] m;
    m = '0;
    m[d] = 1'b1;
    an_in  = ~m;
    seg_in = s;
    repeat (6) @(negedge clk);
  endtask

  task automatic scan(input seg7_t s0, input seg7_t s1, input seg7_t s2, input seg7_t s3);
    strobe(0, s0);
    strobe(1, s1);
    strobe(2, s2);
    strobe(3, s3);
  endtask

  task automatic idle(input int n);
    an_in  = '1;
    seg_in = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic push(input logic [15:0] bcd, input logic [3:0] dv);
    exp_t e;
    e.bcd = bcd;
    e.dv  = dv;
    exp_q.push_back(e);
  endtask

  initial begin
    an_in  = '1;
    seg_in = '1;
    frame_if.frame_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bcd", frame_if.bcd_out, 16'hFFFF);
    check("rst_fv", frame_if.frame_valid, 0);
    check("rst_dv", frame_if.digit_valid, 0);
    check("rst_overlap", overlap_err, 0);
    check("rst_code", code_err, 0);

    // Reset asserted mid-scan
    rst_n = 1'b1;
    strobe(0, SEG_4);
    strobe(1, SEG_3);
    an_in  = 4'b1011;
    seg_in = SEG_2;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", frame_if.bcd_out, 16'hFFFF);
    check("midrst_fv", frame_if.frame_valid, 0);
    repeat (3) @(negedge clk);
    check("midrst_hold_bcd", frame_if.bcd_out, 16'hFFFF);
    check("midrst_hold_fv", frame_if.frame_valid, 0);
    rst_n = 1'b1;
    idle(4);

    // Stable "1234" frame after three rounds
    frame_if.frame_ready = 1'b1;
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    push(16'h1234, 4'hF);
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    idle(8);
    drain("stable_drain");

    // Glitch filter on digit 2
    strobe(0, SEG_4); strobe(1, SEG_3); strobe(2, SEG_8); strobe(3, SEG_1);
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    strobe(0, SEG_4);
    strobe(1, SEG_3);
    push(16'h1234, 4'hF);
    strobe(2, SEG_2);
    idle(8);
    drain("glitch_drain");

    // Blank and invalid digits
    base = code_err_cnt;
    scan(SEG_BAD, SEG_3, SEG_2, SEG_BLANK);
    scan(SEG_BAD, SEG_3, SEG_2, SEG_BLANK);
    push(16'hF23E, 4'b0110);
    scan(SEG_BAD, SEG_3, SEG_2, SEG_BLANK);
    idle(8);
    drain("blank_drain");
    check("blank_code_err_pulses", code_err_cnt - base, 1);

    // Backpressure while the digits change
    frame_if.frame_ready = 1'b0;
    base = code_err_cnt;
    scan(SEG_BAD, SEG_3, SEG_2, SEG_BLANK);
    idle(4);
    check("bp_fv_up", frame_if.frame_valid, 1);
    check("bp_code_err_pulses", code_err_cnt - base, 1);
    scan(SEG_6, SEG_7, SEG_8, SEG_9);
    scan(SEG_6, SEG_7, SEG_8, SEG_9);
    scan(SEG_6, SEG_7, SEG_8, SEG_9);
    check("bp_hold_bcd", frame_if.bcd_out, 16'hF23E);
    check("bp_hold_dv", frame_if.digit_valid, 4'b0110);
    check("bp_hold_fv", frame_if.frame_valid, 1);
    push(16'hF23E, 4'b0110);
    push(16'h9876, 4'hF);
    frame_if.frame_ready = 1'b1;
    idle(8);
    drain("bp_drain");

    // Overlapping anodes
    base = overlap_cnt;
    an_in  = 4'b1100;
    seg_in = SEG_8;
    repeat (5) @(negedge clk);
    idle(6);
    check("overlap_pulses", overlap_cnt - base, 1);

    // Reset while a frame is pending: no frame afterwards
    frame_if.frame_ready = 1'b0;
    scan(SEG_6, SEG_7, SEG_8, SEG_9);
    idle(4);
    check("pend_fv", frame_if.frame_valid, 1);
    check("pend_bcd", frame_if.bcd_out, 16'h9876);
    rst_n = 1'b0;
    #1;
    check("abort_fv", frame_if.frame_valid, 0);
    check("abort_bcd", frame_if.bcd_out, 16'hFFFF);
    check("abort_dv", frame_if.digit_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_if.frame_ready = 1'b1;
    idle(20);
    check("abort_fv_after", frame_if.frame_valid, 0);

`ifdef SEG7_SCAN_TIMEOUT_EN
    strobe(0, SEG_1);
    idle(90);
    check("stale_before", stale, 0);
    idle(20);
    check("stale_set", stale, 1);
    strobe(0, SEG_1);
    check("stale_clear", stale, 0);
    idle(2);
`else
    check("stale_tied", stale, 0);
`endif

    drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment display drivers.
- Monitors a multiplexed, common-anode 7-segment bus (segment lines plus per-digit anode strobes) driven by an external scanner.
- Decodes each strobed digit back to BCD and filters it for stability.
- Presents a full multi-digit BCD frame to downstream logic over a valid/ready handshake; used for display loop-back checking and for reading legacy front panels.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits / anode lines.
- SETTLE, 2: cycles a single anode must stay active before the segments are sampled.
- STABLE_CNT, 3: consecutive identical samples of one digit required to commit it.
- TIMEOUT, 65535: idle cycles before the stale flag asserts (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit)
- an_in  in  NUM_DIGITS  anode strobes, active-low, bit i = digit i
- bcd_out  out  4*NUM_DIGITS  frame, digit i at [4i+3:4i]
- digit_valid  out  NUM_DIGITS  1 = digit i decoded to 0-9 in the current frame
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts the frame
- overlap_err  out  1  one-cycle pulse: more than one anode active
- code_err  out  1  one-cycle pulse: committed pattern not in the decode table
- stale  out  1  no strobe within TIMEOUT (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0 except bcd_out = all 4'hF. All internal counters, candidates and commit flags cleared.
- Input sync: seg_in and an_in each pass through a 2-FF synchronizer. All timing below is counted in synchronized cycles.
- Strobe tracking:
  - When exactly one an_in bit is low and unchanged, a settle counter increments.
  - The sample is taken on the cycle the counter reaches SETTLE, once per strobe.
  - If no anode is low, or the anode changes, the settle counter clears.
  - If two or more anodes are low: overlap_err pulses once on the first such cycle, the settle counter clears, and no sample is taken.
- Decode (active-low patterns):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - 1111111 is blank and maps to 4'hF.
  - Any other pattern is invalid and maps to 4'hE.
- Stability filter, per digit (candidate code plus saturating count):
  - Sample equal to the candidate: count increments.
  - Sample different: candidate is replaced and count is set to 1.
  - On the sample where count reaches STABLE_CNT, the digit commits: the committed code is updated and the digit's commit flag is set.
  - code_err pulses on a commit of 4'hE.
  - Further identical samples re-commit every sample (keeps the frame fresh).
- Framing:
  - While frame_valid=0 and every commit flag is set, the next cycle latches bcd_out and digit_valid (1 where the code is 0-9), sets frame_valid, and clears all commit flags.
  - bcd_out and digit_valid are held constant while frame_valid=1.
  - frame_valid drops the cycle after frame_valid&&frame_ready.
  - A commit on the same cycle as the handshake counts toward the next frame.
  - Latency: last required commit to frame_valid = 1 cycle.
- Boundaries:
  - A digit never strobed blocks frame_valid indefinitely; this is not an error.
  - frame_ready held high permanently yields one frame per full stable scan.
  - Reset asserted mid-frame aborts the frame immediately; no partial frame is emitted.

Optional Feature:
- Macro: SEG7_SCAN_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter counts cycles without a sample and clears on any sample.
  - At TIMEOUT, stale is set and all candidate counts are cleared.
  - stale clears on the next sample.
  - A frame is never emitted while stale=1.
- Undefined: no counter is built, stale is tied to 0, and TIMEOUT is ignored.

Decomposition:
- Package seg7_pkg holds:
  - the ten active-low digit patterns and SEG_BLANK=7'b1111111;
  - BCD_BLANK=4'hF and BCD_INVALID=4'hE;
  - typedef seg7_t (7-bit) and bcd_t (4-bit).
- One combinational sub-module, seg7_to_bcd: seg7_t in, bcd_t out, table lookup only. Instantiated once on the sampled bus.

Test Plan:
- Reset check: assert rst_n=0 mid-scan -> bcd_out=16'hFFFF, frame_valid=0, errors 0, all held while reset is asserted.
- Stable frame: scan "1234" (digit0=0011001, digit1=0110000, digit2=0100100, digit3=1111001) three full rounds with SETTLE≥2 -> frame_valid with bcd_out=16'h1234, digit_valid=4'hF.
- Glitch filter: digit2 shows 0000000 once, then 0100100 ×3 -> committed value 2, not 8; the frame is emitted only after the third matching sample.
- Blank and invalid: digit3 blank and digit0 = 0110110, each for 3 samples -> bcd_out[15:12]=F, bcd_out[3:0]=E, digit_valid=4'b0110, code_err pulses once for each committing sample of digit0.
- Backpressure: frame_ready=0 for 50 cycles while the digits change -> bcd_out is unchanged until the handshake; after ready, the next frame reflects the new values.
- Overlap / timeout: an_in=4'b1100 for 5 cycles -> exactly one overlap_err pulse and no sample. With SEG7_SCAN_TIMEOUT_EN and TIMEOUT=100, stop strobing -> stale=1 at idle cycle 100, and it clears on the next sample.
